// File: rtl/alu_share_ctrl.sv
// Shared 32-bit ALU with a two-port round-robin sequencer: accept, execute, respond.
// The ALU is combinational; the controller owns operand and response registers.

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluc,
    output logic [31:0] r,
    output logic        zero,
    output logic        carry,
    output logic        negative,
    output logic        overflow
);
    logic [32:0] sum_c;

    // carry is carry-out for add codes and borrow for subtract codes
    always_comb begin
        sum_c    = '0;
        r        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (aluc)
            4'b0000, 4'b0010: begin
                sum_c    = {1'b0, a} + {1'b0, b};
                r        = sum_c[31:0];
                carry    = sum_c[32];
                overflow = aluc[1] & (a[31] == b[31]) & (r[31] != a[31]);
            end
            4'b0001, 4'b0011: begin
                sum_c    = {1'b0, a} - {1'b0, b};
                r        = sum_c[31:0];
                carry    = sum_c[32];
                overflow = aluc[1] & (a[31] != b[31]) & (r[31] != a[31]);
            end
            4'b0100:          r = a & b;
            4'b0101:          r = a | b;
            4'b0110:          r = a ^ b;
            4'b0111:          r = ~(a | b);
            4'b1000, 4'b1001: r = {b[15:0], 16'h0000};
            4'b1010:          r = 32'(a < b);
            4'b1011:          r = 32'($signed(a) < $signed(b));
            4'b1100:          r = 32'($signed(b) >>> a[4:0]);
            4'b1101:          r = b >> a[4:0];
            default:          r = b << a[4:0];
        endcase
    end

    assign zero     = (r == 32'h0000_0000);
    assign negative = r[31];
endmodule

module alu_share_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_aluc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_aluc,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_r,
    output logic [3:0]       resp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;
    logic [31:0]       op_a_q, op_a_d, op_b_q, op_b_d;
    logic [3:0]        op_aluc_q, op_aluc_d;
    logic              op_id_q, op_id_d;
    logic [31:0]       resp_r_q, resp_r_d;
    logic [3:0]        resp_flags_q, resp_flags_d;
    logic              resp_id_q, resp_id_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic [31:0]       alu_r;
    logic              alu_zero, alu_carry, alu_neg, alu_ovf;
    logic              accept_c;

    alu u_alu (
        .a        (op_a_q),
        .b        (op_b_q),
        .aluc     (op_aluc_q),
        .r        (alu_r),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .negative (alu_neg),
        .overflow (alu_ovf)
    );

    // Round-robin grant, only while idle; prio names the favoured port on a tie
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && (!req1_valid || !prio_q)) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    assign accept_c = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_aluc_d    = op_aluc_q;
        op_id_d      = op_id_q;
        resp_r_d     = resp_r_q;
        resp_flags_d = resp_flags_q;
        resp_id_d    = resp_id_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d   = EXEC;
                    op_id_d   = req1_ready;
                    op_a_d    = req1_ready ? req1_a    : req0_a;
                    op_b_d    = req1_ready ? req1_b    : req0_b;
                    op_aluc_d = req1_ready ? req1_aluc : req0_aluc;
                end
            end
            EXEC: begin
                state_d      = RESP;
                resp_r_d     = alu_r;
                resp_flags_d = {alu_ovf, alu_neg, alu_carry, alu_zero};
                resp_id_d    = op_id_q;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d    = IDLE;
                    prio_d     = ~resp_id_q;
                    op_count_d = op_count_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_aluc_q    <= '0;
            op_id_q      <= 1'b0;
            resp_r_q     <= '0;
            resp_flags_q <= '0;
            resp_id_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_aluc_q    <= op_aluc_d;
            op_id_q      <= op_id_d;
            resp_r_q     <= resp_r_d;
            resp_flags_q <= resp_flags_d;
            resp_id_q    <= resp_id_d;
            op_count_q   <= op_count_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_id    = resp_id_q;
    assign resp_r     = resp_r_q;
    assign resp_flags = resp_flags_q;
    assign op_count   = op_count_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed vector table, corner sequences and a random run
// against a transaction-level model; a CNT_W=2 twin checks counter wrap.

module tb_alu_share_ctrl;
    localparam int unsigned CNT_W = 16;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk, rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_aluc, req1_aluc;
    logic        resp_valid, resp_ready, resp_id, busy;
    logic [31:0] resp_r;
    logic [3:0]  resp_flags;
    logic [CNT_W-1:0] op_count;
    logic        w_req0_ready, w_req1_ready, w_resp_valid, w_resp_id, w_busy;
    logic [31:0] w_resp_r;
    logic [3:0]  w_resp_flags;
    logic [1:0]  w_op_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_share_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_r(resp_r),
        .resp_flags(resp_flags), .busy(busy), .op_count(op_count)
    );

    alu_share_ctrl #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
        .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
        .resp_valid(w_resp_valid), .resp_ready(resp_ready), .resp_id(w_resp_id), .resp_r(w_resp_r),
        .resp_flags(w_resp_flags), .busy(w_busy), .op_count(w_op_count)
    );

    typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] aluc; logic [31:0] r; logic [3:0] f; } vec_t;
    typedef struct { logic id; logic [31:0] r; logic [3:0] f; } rsp_t;

    int          n_cmp, n_err;
    vec_t        vecs[16];
    rsp_t        hs_q[$];
    int          grant_q[$];
    // model: one transaction in flight, age counts cycles since its accept edge
    logic        m_pend, m_prio, m_id, m_sh_id;
    int          m_age;
    int unsigned m_cnt;
    logic [31:0] m_r, m_sh_r;
    logic [3:0]  m_f, m_sh_f;
    logic        acc0, acc1, cap_rdy0, cap_rdy1, cap_rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out, got no event, required one (t=%0t)", name, $time);
    endtask

    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                    output logic [31:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, full;
        logic c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        full = 0;
        r = '0;
        case (op)
            4'd0, 4'd2: begin
                full = ua + ub;
                r = full[31:0];
                c = (full > 64'sd4294967295);
                v = (op == 4'd2) && ((sa + sb > MAXS) || (sa + sb < MINS));
            end
            4'd1, 4'd3: begin
                full = ua - ub;
                r = full[31:0];
                c = (ua < ub);
                v = (op == 4'd3) && ((sa - sb > MAXS) || (sa - sb < MINS));
            end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = ~(a | b);
            4'd8, 4'd9: r = b << 16;
            4'd10: r = 32'(ua < ub);
            4'd11: r = 32'(sa < sb);
            4'd12: begin full = sb >>> a[4:0]; r = full[31:0]; end
            4'd13: r = b >> a[4:0];
            default: r = b << a[4:0];
        endcase
        f = {v, r[31], c, (r == 32'h0)};
    endfunction

    task automatic model_reset();
        m_pend = 1'b0; m_prio = 1'b0; m_age = 0; m_cnt = 0;
        m_id = 1'b0; m_r = '0; m_f = '0;
        m_sh_id = 1'b0; m_sh_r = '0; m_sh_f = '0;
    endtask

    // Check all outputs mid-cycle, then advance the model across the coming edge.
    task automatic step();
        logic e0, e1, e_rv;
        @(negedge clk);
        e0 = 1'b0;
        e1 = 1'b0;
        if (!m_pend) begin
            if (req0_valid && req1_valid) begin
                if (m_prio) e1 = 1'b1; else e0 = 1'b1;
            end else if (req0_valid) e0 = 1'b1;
            else if (req1_valid) e1 = 1'b1;
        end
        e_rv = m_pend && (m_age >= 2);
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("resp_id", 32'(resp_id), 32'(m_sh_id));
        chk("resp_r", resp_r, m_sh_r);
        chk("resp_flags", 32'(resp_flags), 32'(m_sh_f));
        chk("op_count", 32'(op_count), 32'(m_cnt[15:0]));
        chk("w_op_count", 32'(w_op_count), 32'(m_cnt[1:0]));
        chk("w_readies", 32'({w_req0_ready, w_req1_ready, w_resp_valid, w_busy}), 32'({e0, e1, e_rv, m_pend}));
        chk("w_resp", 32'({w_resp_id, w_resp_flags}) ^ w_resp_r, 32'({m_sh_id, m_sh_f}) ^ m_sh_r);
        cap_rdy0 = req0_ready;
        cap_rdy1 = req1_ready;
        cap_rv = resp_valid;
        acc0 = e0;
        acc1 = e1;
        if (m_pend) begin
            if (e_rv && resp_ready) begin
                hs_q.push_back('{id: resp_id, r: resp_r, f: resp_flags});
                m_cnt++;
                m_prio = ~m_id;
                m_pend = 1'b0;
            end else begin
                m_age++;
                if (m_age == 2) begin
                    m_sh_id = m_id; m_sh_r = m_r; m_sh_f = m_f;
                end
            end
        end else if (e0 || e1) begin
            m_pend = 1'b1;
            m_age = 1;
            m_id = e1;
            grant_q.push_back(int'(e1));
            if (e1) ref_alu(req1_a, req1_b, req1_aluc, m_r, m_f);
            else    ref_alu(req0_a, req0_b, req0_aluc, m_r, m_f);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_aluc = op; end
        else    begin req0_valid = v; req0_a = a; req0_b = b; req0_aluc = op; end
    endtask

    task automatic wait_hs(input int target, input string name);
        int n = 0;
        while (hs_q.size() < target && n < 40) begin step(); n++; end
        if (hs_q.size() < target) timeout(name);
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int n = 0;
        set_req(id, 1'b1, a, b, op);
        do begin step(); n++; end while (!(id ? acc1 : acc0) && n < 40);
        if (!(id ? acc1 : acc0)) timeout("accept");
        set_req(id, 1'b0, a, b, op);
        wait_hs(hs_q.size() + 1, "response");
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] bp_r;
        logic [3:0]  bp_f;
        int n;
        n_cmp = 0; n_err = 0;
        vecs[0]  = '{32'h1C000E02, 32'hFFFFFFFF, 4'd0,  32'h1C000E01, 4'b0010};
        vecs[1]  = '{32'h80380802, 32'h80380802, 4'd3,  32'h00000000, 4'b0001};
        vecs[2]  = '{32'h1C000E02, 32'hE3FFF1FD, 4'd4,  32'h00000000, 4'b0001};
        vecs[3]  = '{32'h7FC00E60, 32'h7F39081E, 4'd2,  32'hFEF9167E, 4'b1100};
        vecs[4]  = '{32'h00000001, 32'h00000002, 4'd1,  32'hFFFFFFFF, 4'b0110};
        vecs[5]  = '{32'hF0F0F0F0, 32'h0F0F0F0F, 4'd5,  32'hFFFFFFFF, 4'b0100};
        vecs[6]  = '{32'h12345678, 32'h12345678, 4'd6,  32'h00000000, 4'b0001};
        vecs[7]  = '{32'h00000000, 32'h00000000, 4'd7,  32'hFFFFFFFF, 4'b0100};
        vecs[8]  = '{32'h00000000, 32'h0000ABCD, 4'd8,  32'hABCD0000, 4'b0100};
        vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, 4'd10, 32'h00000000, 4'b0001};
        vecs[10] = '{32'hFFFFFFFF, 32'h00000001, 4'd11, 32'h00000001, 4'b0000};
        vecs[11] = '{32'h00000004, 32'h80000000, 4'd12, 32'hF8000000, 4'b0100};
        vecs[12] = '{32'h0000001F, 32'h80000000, 4'd13, 32'h00000001, 4'b0000};
        vecs[13] = '{32'h00000004, 32'h0000000F, 4'd14, 32'h000000F0, 4'b0000};
        vecs[14] = '{32'h80000000, 32'h00000001, 4'd3,  32'h7FFFFFFF, 4'b1000};
        vecs[15] = '{32'hFFFFFFFF, 32'h00000001, 4'd0,  32'h00000000, 4'b0011};

        rst_n = 1'b0; resp_ready = 1'b1;
        set_req(1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0, '0);
        model_reset();
        #1;
        chk("rst_outputs", 32'({req0_ready, req1_ready, resp_valid, resp_id, busy, resp_flags}), 32'h0);
        chk("rst_resp_r", resp_r, 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors, alternating requesters
        for (int i = 0; i < 16; i++) begin
            hs_q.delete();
            run_op(1'(i % 2), vecs[i].a, vecs[i].b, vecs[i].aluc);
            if (hs_q.size() == 1) begin
                chk($sformatf("vec%0d_id", i), 32'(hs_q[0].id), 32'(i % 2));
                chk($sformatf("vec%0d_r", i), hs_q[0].r, vecs[i].r);
                chk($sformatf("vec%0d_flags", i), 32'(hs_q[0].f), 32'(vecs[i].f));
            end
        end

        // Both requesters held valid: grants alternate starting at 0
        hs_q.delete(); grant_q.delete();
        set_req(1'b0, 1'b1, 32'h80380802, 32'h80380802, 4'b0011);
        set_req(1'b1, 1'b1, 32'h1C000E02, 32'hE3FFF1FD, 4'b0100);
        n = 0;
        while (grant_q.size() < 4 && n < 40) begin step(); n++; end
        if (grant_q.size() < 4) timeout("rr_grants");
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_hs(4, "rr_responses");
        for (int k = 0; k < 4 && k < grant_q.size() && k < hs_q.size(); k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(grant_q[k]), 32'(k % 2));
            chk($sformatf("rr_r%0d", k), hs_q[k].r, 32'h0);
            chk($sformatf("rr_flags%0d", k), 32'(hs_q[k].f), 32'h1);
        end

        // Backpressure with a waiting requester
        hs_q.delete();
        resp_ready = 1'b0;
        set_req(1'b0, 1'b1, 32'h00000005, 32'h00000007, 4'd0);
        n = 0;
        do begin step(); n++; end while (!acc0 && n < 40);
        req0_valid = 1'b0;
        set_req(1'b1, 1'b1, 32'h00000003, 32'h00000009, 4'd6);
        n = 0;
        do begin step(); n++; end while (!cap_rv && n < 40);
        if (!cap_rv) timeout("bp_resp_valid");
        bp_r = resp_r; bp_f = resp_flags;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_r_stable", resp_r, bp_r);
            chk("bp_flags_stable", 32'(resp_flags), 32'(bp_f));
            chk("bp_busy", 32'(busy), 32'h1);
            chk("bp_readies", 32'({req0_ready, req1_ready}), 32'h0);
        end
        chk("bp_r_value", bp_r, 32'h0000000C);
        resp_ready = 1'b1;
        step();
        chk("bp_handshake", 32'(hs_q.size()), 32'h1);
        step();
        chk("bp_next_accept", 32'(cap_rdy1), 32'h1);
        req1_valid = 1'b0;
        wait_hs(2, "bp_req1_resp");

        // Reset during EXEC, with both requests held across reset; prio made 1 first
        run_op(1'b0, 32'h1, 32'h1, 4'd0);
        hs_q.delete();
        set_req(1'b0, 1'b1, 32'h11111111, 32'h22222222, 4'd0);
        n = 0;
        do begin step(); n++; end while (!acc0 && n < 40);
        set_req(1'b0, 1'b1, 32'h0000000A, 32'h00000003, 4'd1);
        set_req(1'b1, 1'b1, 32'h0000000B, 32'h00000004, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_op_count", 32'(op_count), 32'h0);
        chk("mid_rst_w_op_count", 32'(w_op_count), 32'h0);
        chk("mid_rst_resp", 32'({resp_id, resp_flags}) | resp_r, 32'h0);
        chk("mid_rst_readies", 32'({req0_ready, req1_ready}), 32'h2);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_grant0", 32'(cap_rdy0), 32'h1);
        set_req(1'b0, 1'b0, '0, '0, '0);
        req1_valid = 1'b0;
        wait_hs(1, "post_rst_resp");
        if (hs_q.size() > 0) begin
            chk("post_rst_id", 32'(hs_q[0].id), 32'h0);
            chk("post_rst_r", hs_q[0].r, 32'h00000007);
        end
        chk("post_rst_count", 32'(op_count), 32'h1);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            step();
            if (req0_valid ? acc0 : ($urandom_range(0, 2) == 0)) begin
                set_req(1'b0, 1'($urandom_range(0, 1)), pick(), pick(), 4'($urandom_range(0, 15)));
                if (!acc0) req0_valid = 1'b1;
            end
            if (req1_valid ? acc1 : ($urandom_range(0, 2) == 0)) begin
                set_req(1'b1, 1'($urandom_range(0, 1)), pick(), pick(), 4'($urandom_range(0, 15)));
                if (!acc1) req1_valid = 1'b1;
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and two-port arbiter for the shared 32-bit `alu`. It accepts operation requests (`a`, `b`, `aluc`) from two requesters over valid/ready handshakes and arbitrates between them round-robin. It registers the winning operands, drives one internal `alu` instance for one execute cycle, and returns the result and status flags on a single tagged response channel. It sits between the multi-cycle datapath controllers and the combinational ALU, and is the only block that drives the ALU.

## Interface
- `CNT_W`, 16, width of the completed-operation counter `op_count`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester N presents an operation.
- `req0_ready` / `req1_ready`  out  1  controller accepts requester N this cycle.
- `req0_a` / `req1_a`  in  32  operand a.
- `req0_b` / `req1_b`  in  32  operand b.
- `req0_aluc` / `req1_aluc`  in  4  ALU operation code, passed to `alu` unchanged.
- `resp_valid`  out  1  response holds a result.
- `resp_ready`  in  1  consumer takes the response.
- `resp_id`  out  1  requester that owns the response.
- `resp_r`  out  32  ALU result.
- `resp_flags`  out  4  {overflow, negative, carry, zero} as produced by `alu`.
- `busy`  out  1  state is not IDLE.
- `op_count`  out  CNT_W  number of completed response handshakes.

## Operation
- The FSM has three states.
  - IDLE: arbitrate. Go to EXEC on an accept.
  - EXEC: ALU evaluates the registered operands. Always go to RESP on the next edge.
  - RESP: hold the response. Go to IDLE on `resp_valid && resp_ready`.
- Arbitration is combinational in IDLE only. A priority pointer `prio` (reset 0) names the favoured requester.
  - One valid: that requester gets ready.
  - Both valid: `req[prio]_ready=1`; the other stays 0.
  - Neither valid: both readies 0.
- Outside IDLE, both readies are 0.
- At most one ready is high in any cycle.
- Accept means `reqN_valid && reqN_ready`. On accept, latch a, b, aluc and id into operand registers.
- The `alu` instance is fed only from the operand registers, never directly from the request ports.
- At the EXEC→RESP edge, capture the `alu` r, zero, carry, negative and overflow outputs into the response registers. Response registers are stable for the whole of RESP.
- On the response handshake:
  - `prio <= ~resp_id`.
  - `op_count <= op_count + 1`; it wraps modulo 2^CNT_W, so all-ones+1 gives 0.
- All 16 `aluc` codes are legal. The controller never interprets them, and flag semantics belong to `alu`.
- Requesters must hold a, b and aluc stable while valid is high and not yet accepted. The controller samples them only in the accept cycle.

## Timing
- Reset values:
  - state IDLE, `prio`=0.
  - `req0_ready` and `req1_ready` follow IDLE arbitration (0 with no valid).
  - `resp_valid`=0, `resp_id`=0, `resp_r`=0, `resp_flags`=0.
  - `busy`=0, `op_count`=0.
- Accept at edge T: EXEC during cycle T+1, and `resp_valid`=1 from T+2.
- Minimum request-to-response latency is 2 cycles. Peak throughput is one operation per 3 cycles (accept, EXEC, 1-cycle RESP).
- Backpressure: with `resp_ready`=0, RESP holds indefinitely, and `resp_*` and `busy` stay constant.
- There is no accept in the same cycle as a response handshake. The next accept is earliest one cycle after returning to IDLE.
- `busy` is 1 in EXEC and RESP, and goes low on the edge where the handshake completes.
- Asynchronous reset asserted in EXEC or RESP aborts the transaction. No response is produced, `op_count` is unchanged from reset value 0, and all outputs take their reset values immediately.
- A request valid held across reset is accepted normally in the first IDLE cycle after `rst_n` deasserts.

## Test plan
- Single addu on req0:
  - Stimulus: a=0x1C000E02, b=0xFFFFFFFF, aluc=0000, `resp_ready`=1.
  - Response: ready high in the accept cycle; 2 cycles later `resp_valid`=1, `resp_id`=0, r=0x1C000E01, flags carry=1 overflow=0 zero=0; `op_count`=1 after the handshake.
- Simultaneous requests, repeated:
  - Stimulus: req0 sub a=b=0x80380802 (aluc 0011); req1 and a=0x1C000E02 b=0xE3FFF1FD (aluc 0100); both held valid for 4 operations.
  - Response: grant order 0,1,0,1. req0 responses r=0 zero=1; req1 responses r=0 zero=1.
- Backpressure:
  - Stimulus: hold `resp_ready`=0 for 5 cycles after `resp_valid`, while req1 is valid.
  - Response: `resp_*` stable, both readies 0, `busy`=1. The handshake occurs only when `resp_ready` rises; req1 is accepted on the following cycle.
- Overflow passthrough:
  - Stimulus: req1 add a=0x7FC00E60, b=0x7F39081E, aluc 0010.
  - Response: `resp_flags` overflow=1 negative=1, r=0xFEF9167E.
- Reset mid-operation:
  - Stimulus: drop `rst_n` during EXEC.
  - Response: `resp_valid`, `busy`, `op_count` and `prio` are 0 immediately. No response appears after release, and the next accepted request completes normally.
- Counter wrap:
  - Stimulus: CNT_W=2, 5 back-to-back operations.
  - Response: `op_count` sequence 1,2,3,0,1.
